hsv_core_commit: RTL

In-order retirement stage of the hsv core, directly downstream of the ctrlstatus, alu, foo, mem and branch units. It accepts at most one completed instruction per cycle, the one whose token equals the current commit token. It then writes the register file, drives the `ctrl_*` sideband into the ctrlstatus FSM, and takes part in the global flush handshake. It owns `commit_token` and `flush_ack_commit`.

---
 rtl/hsv_core_pkg.sv | 26 ++
 rtl/hsv_core_commit_select.sv | 28 ++
 rtl/hsv_core_commit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core: retirement entry, token/word types, commit FSM encoding.
// Types and constants only; no timing or flow-control behaviour of its own.
package hsv_core_pkg;

  typedef logic [31:0] word;
  typedef logic [2:0]  insn_token;

  localparam int COMMIT_UNITS = 5;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    insn_token  token;
    word        pc;
    word        next_pc;
    logic       trap;
    logic [4:0] cause;
    word        tval;
    logic       jump;
    logic       wr_en;
    logic [4:0] rd;
    word        rd_value;
  } commit_data_t;

endpackage

// File: rtl/hsv_core_commit_select.sv
// Token matcher: grants the lowest-index valid unit whose token equals the commit token.
// Purely combinational; no grant at all while enable is low.
module hsv_core_commit_select
  import hsv_core_pkg::*;
(
  input  logic                                 enable,
  input  insn_token                            token,
  input  logic         [COMMIT_UNITS-1:0]      valid,
  input  commit_data_t [COMMIT_UNITS-1:0]      data,
  output logic         [COMMIT_UNITS-1:0]      grant,
  output logic                                 hit,
  output commit_data_t                         sel
);

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    sel   = '0;
    for (int i = 0; i < COMMIT_UNITS; i++) begin
      if (enable && !hit && valid[i] && (data[i].token == token)) begin
        grant[i] = 1'b1;
        hit      = 1'b1;
        sel      = data[i];
      end
    end
  end

endmodule

// File: rtl/hsv_core_commit.sv
// In-order retirement: accepts the entry matching commit_token, registers ctrl_*/wb_* one cycle later.
// Ready is combinational and held low while a flush is pending or in progress.
module hsv_core_commit
  import hsv_core_pkg::*;
(
  input  logic         clk_core,
  input  logic         rst_core_n,

  input  commit_data_t alu_data,
  input  logic         alu_valid_i,
  output logic         alu_ready_o,
  input  commit_data_t foo_data,
  input  logic         foo_valid_i,
  output logic         foo_ready_o,
  input  commit_data_t mem_data,
  input  logic         mem_valid_i,
  output logic         mem_ready_o,
  input  commit_data_t branch_data,
  input  logic         branch_valid_i,
  output logic         branch_ready_o,
  input  commit_data_t ctrlstatus_data,
  input  logic         ctrlstatus_valid_i,
  output logic         ctrlstatus_ready_o,

  input  logic         flush_req,
  output logic         flush_ack_commit,
  input  logic         ctrl_begin_irq,

  output insn_token    commit_token,
  output logic         ctrl_commit,
  output logic         ctrl_flush_begin,
  output logic         ctrl_trap,
  output logic [4:0]   ctrl_trap_cause,
  output word          ctrl_trap_value,
  output word          ctrl_next_pc,

  output logic         wb_en,
  output logic [4:0]   wb_rd,
  output word          wb_data
);

  commit_data_t [COMMIT_UNITS-1:0] unit_data;
  logic         [COMMIT_UNITS-1:0] unit_valid;
  logic         [COMMIT_UNITS-1:0] grant;
  logic                            hit;
  logic                            accept_en;
  commit_data_t                    sel;

  logic [0:0]  state_q, state_d;
  logic        seen_q, seen_d;
  insn_token   token_q, token_d;
  logic        flush_ack_q, flush_ack_d;
  logic        commit_q, commit_d;
  logic        flush_begin_q, flush_begin_d;
  logic        trap_q, trap_d;
  logic [4:0]  trap_cause_q, trap_cause_d;
  word         trap_value_q, trap_value_d;
  word         next_pc_q, next_pc_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  word         wb_data_q, wb_data_d;

  assign unit_data  = {ctrlstatus_data, branch_data, mem_data, foo_data, alu_data};
  assign unit_valid = {ctrlstatus_valid_i, branch_valid_i, mem_valid_i, foo_valid_i, alu_valid_i};

  // An external flush arriving in RUN wins over any same-cycle match.
  assign accept_en = (state_q == ST_RUN) && !flush_req;

  hsv_core_commit_select u_select (
    .enable (accept_en),
    .token  (token_q),
    .valid  (unit_valid),
    .data   (unit_data),
    .grant  (grant),
    .hit    (hit),
    .sel    (sel)
  );

  assign alu_ready_o        = grant[0];
  assign foo_ready_o        = grant[1];
  assign mem_ready_o        = grant[2];
  assign branch_ready_o     = grant[3];
  assign ctrlstatus_ready_o = grant[4];

  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    token_d       = token_q;
    flush_ack_d   = flush_req;
    commit_d      = 1'b0;
    flush_begin_d = 1'b0;
    trap_d        = 1'b0;
    trap_cause_d  = '0;
    trap_value_d  = '0;
    next_pc_d     = '0;
    wb_en_d       = 1'b0;
    wb_rd_d       = '0;
    wb_data_d     = '0;

    if (state_q == ST_RUN) begin
      if (flush_req) begin
        state_d = ST_FLUSH;
        seen_d  = 1'b1;
        token_d = '0;
      end else if (hit) begin
        if (ctrl_begin_irq) begin
          flush_begin_d = 1'b1;
          next_pc_d     = sel.pc;
          state_d       = ST_FLUSH;
        end else if (sel.trap) begin
          trap_d        = 1'b1;
          trap_cause_d  = sel.cause;
          trap_value_d  = sel.tval;
          flush_begin_d = 1'b1;
          state_d       = ST_FLUSH;
        end else begin
          commit_d  = 1'b1;
          wb_en_d   = sel.wr_en && (sel.rd != 5'd0);
          wb_rd_d   = sel.rd;
          wb_data_d = sel.rd_value;
          if (sel.jump) begin
            flush_begin_d = 1'b1;
            next_pc_d     = sel.next_pc;
            state_d       = ST_FLUSH;
          end else begin
            token_d = token_q + 1'b1;
          end
        end
      end
    end else begin
      // Leave only after flush_req has been seen high and then drops.
      if (flush_req) begin
        seen_d  = 1'b1;
        token_d = '0;
      end else if (seen_q) begin
        seen_d  = 1'b0;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      state_q       <= ST_RUN;
      seen_q        <= 1'b0;
      token_q       <= '0;
      flush_ack_q   <= 1'b0;
      commit_q      <= 1'b0;
      flush_begin_q <= 1'b0;
      trap_q        <= 1'b0;
      trap_cause_q  <= '0;
      trap_value_q  <= '0;
      next_pc_q     <= '0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      seen_q        <= seen_d;
      token_q       <= token_d;
      flush_ack_q   <= flush_ack_d;
      commit_q      <= commit_d;
      flush_begin_q <= flush_begin_d;
      trap_q        <= trap_d;
      trap_cause_q  <= trap_cause_d;
      trap_value_q  <= trap_value_d;
      next_pc_q     <= next_pc_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign commit_token     = token_q;
  assign flush_ack_commit = flush_ack_q;
  assign ctrl_commit      = commit_q;
  assign ctrl_flush_begin = flush_begin_q;
  assign ctrl_trap        = trap_q;
  assign ctrl_trap_cause  = trap_cause_q;
  assign ctrl_trap_value  = trap_value_q;
  assign ctrl_next_pc     = next_pc_q;
  assign wb_en            = wb_en_q;
  assign wb_rd            = wb_rd_q;
  assign wb_data          = wb_data_q;

endmodule
